// File: rtl/lcd_text_writer_if.sv
// lcd_text_writer_if: frame-buffer writes, refresh control and controller handshake for lcd_text_writer
interface lcd_text_writer_if;
  logic       char_we;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       refresh;
  logic       auto_refresh;
  logic       busy;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       frame_busy;
  logic       frame_done;
  logic       err;
  modport master (
    output char_we, char_addr, char_data, refresh, auto_refresh, busy,
    input  lcd_enable, lcd_bus, frame_busy, frame_done, err
  );
  modport slave (
    input  char_we, char_addr, char_data, refresh, auto_refresh, busy,
    output lcd_enable, lcd_bus, frame_busy, frame_done, err
  );
endinterface

// File: rtl/lcd_text_writer.sv
// lcd_text_writer: 2x16 frame buffer streamed to the LCD controller as 34 busy-paced byte transactions
module lcd_text_writer #(
  parameter int         START_WAIT = 4,
  parameter int         HS_TIMEOUT = 8,
  parameter logic [6:0] ROW0_ADDR  = 7'h00,
  parameter logic [6:0] ROW1_ADDR  = 7'h40
) (
  input logic clk,
  input logic rst_n,
  lcd_text_writer_if.slave bus
);
  localparam int CW = $clog2(START_WAIT > HS_TIMEOUT ? START_WAIT : HS_TIMEOUT) + 1;
  typedef enum logic [2:0] {STARTUP, IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
  state_t          state;
  logic [7:0]      mem [32];
  logic [5:0]      idx;
  logic [CW-1:0]   cnt;
  logic            pending;
  logic            lcd_enable;
  logic [9:0]      lcd_bus;
  logic            frame_busy;
  logic            frame_done;
  logic            err;
  logic [9:0]      word;
  assign bus.lcd_enable = lcd_enable;
  assign bus.lcd_bus    = lcd_bus;
  assign bus.frame_busy = frame_busy;
  assign bus.frame_done = frame_done;
  assign bus.err        = err;
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
    else if (bus.char_we)
      mem[bus.char_addr] <= bus.char_data;
  // Row 1 characters sit two slots past their buffer index because of the two address commands
  always_comb
    word = (idx == 6'd0)  ? {3'b001, ROW0_ADDR} :
           (idx == 6'd17) ? {3'b001, ROW1_ADDR} :
           {2'b10, mem[idx < 6'd17 ? 5'(idx - 6'd1) : 5'(idx - 6'd2)]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= STARTUP;
      idx        <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      lcd_enable <= 1'b0;
      lcd_bus    <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      lcd_enable <= 1'b0;
      frame_done <= 1'b0;
      if (bus.refresh && frame_busy) pending <= 1'b1;
      case (state)
        STARTUP:
          if (cnt == CW'(START_WAIT - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        IDLE:
          if (bus.refresh || pending || bus.auto_refresh) begin
            frame_busy <= 1'b1;
            idx        <= '0;
            pending    <= 1'b0;
            state      <= ISSUE;
          end
        ISSUE:
          if (!bus.busy) begin
            lcd_bus    <= word;
            lcd_enable <= 1'b1;
            cnt        <= '0;
            state      <= WAIT_HI;
          end
        WAIT_HI:
          if (bus.busy) state <= WAIT_LO;
          else if (cnt == CW'(HS_TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= ISSUE;
          end else cnt <= cnt + 1'b1;
        WAIT_LO:
          if (!bus.busy) begin
            if (idx == 6'd33) state <= DONE;
            else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
          end
        DONE: begin
          frame_done <= 1'b1;
          frame_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= STARTUP;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_text_writer.sv
// tb_lcd_text_writer: directed scenarios against a busy-pulsing controller model with an expected-byte scoreboard
module tb_lcd_text_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lcd_text_writer_if ifc();
  lcd_text_writer dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  logic       busy_m = 1'b1;
  assign ifc.busy = busy_m;
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  int         dones = 0;
  int         hold_len = 3;
  int         bcnt = 0;
  bit         force_busy = 1'b1;
  bit         no_resp = 1'b0;
  logic       prev_en = 1'b0;
  logic [9:0] exp_q [$];
  logic [7:0] mdl [32];
  // Controller model: busy rises the edge after lcd_enable and stays high hold_len cycles
  always @(posedge clk)
    if (force_busy) begin
      busy_m <= 1'b1;
      bcnt   <= 0;
    end else if (ifc.lcd_enable && !no_resp) begin
      busy_m <= 1'b1;
      bcnt   <= hold_len;
    end else if (bcnt > 1) bcnt <= bcnt - 1;
    else begin
      busy_m <= 1'b0;
      bcnt   <= 0;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (ifc.lcd_enable) begin
      pulses++;
      chk("enable_not_adjacent", 32'(prev_en), 32'd0);
      chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk($sformatf("lcd_bus_pulse%0d", pulses), 32'(ifc.lcd_bus), 32'(exp_q.pop_front()));
    end
    if (ifc.frame_done) dones++;
    prev_en = ifc.lcd_enable;
  endtask
  task automatic push_frame();
    for (int i = 0; i < 34; i++)
      exp_q.push_back(i == 0 ? 10'h080 : i == 17 ? 10'h0C0 : {2'b10, mdl[i < 17 ? i - 1 : i - 2]});
  endtask
  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = dones;
    n = 0;
    while (dones == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_within_budget", 32'(dones != d0), 32'd1);
  endtask
  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (pulses < target && n < budget) begin
      tick();
      n++;
    end
    chk("pulse_within_budget", 32'(pulses >= target), 32'd1);
  endtask
  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    ifc.char_we   = 1'b1;
    ifc.char_addr = a;
    ifc.char_data = d;
    mdl[a] = d;
    tick();
    ifc.char_we = 1'b0;
  endtask
  task automatic pulse_refresh();
    ifc.refresh = 1'b1;
    tick();
    ifc.refresh = 1'b0;
  endtask
  initial begin
    int p0;
    int d0;
    int n;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    ifc.char_we = 1'b0;
    ifc.char_addr = '0;
    ifc.char_data = '0;
    ifc.refresh = 1'b0;
    ifc.auto_refresh = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    repeat (3) tick();
    chk("rst_lcd_enable", 32'(ifc.lcd_enable), 32'd0);
    chk("rst_lcd_bus", 32'(ifc.lcd_bus), 32'd0);
    chk("rst_frame_busy", 32'(ifc.frame_busy), 32'd0);
    chk("rst_frame_done", 32'(ifc.frame_done), 32'd0);
    chk("rst_err", 32'(ifc.err), 32'd0);
    rst_n = 1'b1;
    // Controller still in its init phase: the frame must stall in ISSUE
    repeat (1000) tick();
    push_frame();
    pulse_refresh();
    repeat (20) tick();
    chk("stall_frame_busy", 32'(ifc.frame_busy), 32'd1);
    chk("stall_no_enable", 32'(pulses), 32'd0);
    repeat (480) tick();
    force_busy = 1'b0;
    wait_done(2000);
    chk("frame1_pulses", 32'(pulses), 32'd34);
    chk("frame1_dones", 32'(dones), 32'd1);
    chk("frame1_drained", 32'(exp_q.size()), 32'd0);
    // HELLO with a slow controller
    for (int i = 0; i < 5; i++) write_char(5'(i), hello[i]);
    hold_len = 150;
    push_frame();
    p0 = pulses;
    pulse_refresh();
    wait_done(34 * 200);
    chk("hello_pulses", 32'(pulses - p0), 32'd34);
    chk("hello_drained", 32'(exp_q.size()), 32'd0);
    // Write to row 1 while the frame is mid-row 0
    hold_len = 20;
    mdl[17] = 8'h41;
    push_frame();
    p0 = pulses;
    pulse_refresh();
    wait_pulses(p0 + 6, 2000);
    write_char(5'd17, 8'h41);
    wait_done(5000);
    chk("midwrite_pulses", 32'(pulses - p0), 32'd34);
    chk("midwrite_drained", 32'(exp_q.size()), 32'd0);
    // Three refreshes during one frame collapse into a single extra frame
    hold_len = 3;
    push_frame();
    push_frame();
    p0 = pulses;
    d0 = dones;
    pulse_refresh();
    repeat (10) tick();
    pulse_refresh();
    repeat (10) tick();
    pulse_refresh();
    repeat (10) tick();
    pulse_refresh();
    wait_done(2000);
    chk("gap_frame_busy_low", 32'(ifc.frame_busy), 32'd0);
    tick();
    chk("gap_frame_busy_high", 32'(ifc.frame_busy), 32'd1);
    wait_done(2000);
    repeat (50) tick();
    chk("pending_pulses", 32'(pulses - p0), 32'd68);
    chk("pending_dones", 32'(dones - d0), 32'd2);
    chk("pending_idle", 32'(ifc.frame_busy), 32'd0);
    chk("pending_drained", 32'(exp_q.size()), 32'd0);
    // Auto refresh held for exactly two frame starts
    push_frame();
    push_frame();
    p0 = pulses;
    d0 = dones;
    ifc.auto_refresh = 1'b1;
    wait_done(2000);
    tick();
    ifc.auto_refresh = 1'b0;
    wait_done(2000);
    repeat (50) tick();
    chk("auto_pulses", 32'(pulses - p0), 32'd68);
    chk("auto_dones", 32'(dones - d0), 32'd2);
    chk("auto_drained", 32'(exp_q.size()), 32'd0);
    // Handshake timeout and retry of the same byte
    chk("err_before_timeout", 32'(ifc.err), 32'd0);
    no_resp = 1'b1;
    exp_q.push_back(10'h080);
    push_frame();
    p0 = pulses;
    pulse_refresh();
    wait_pulses(p0 + 1, 100);
    n = 0;
    while (!ifc.err && n < 50) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd8);
    no_resp = 1'b0;
    wait_done(2000);
    chk("err_sticky", 32'(ifc.err), 32'd1);
    chk("retry_pulses", 32'(pulses - p0), 32'd35);
    chk("retry_drained", 32'(exp_q.size()), 32'd0);
    // Reset mid-frame at idx 20, then a fresh frame shows a cleared buffer
    push_frame();
    p0 = pulses;
    pulse_refresh();
    wait_pulses(p0 + 21, 2000);
    rst_n = 1'b0;
    tick();
    chk("midrst_lcd_enable", 32'(ifc.lcd_enable), 32'd0);
    chk("midrst_frame_busy", 32'(ifc.frame_busy), 32'd0);
    chk("midrst_err", 32'(ifc.err), 32'd0);
    chk("midrst_lcd_bus", 32'(ifc.lcd_bus), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    repeat (10) tick();
    push_frame();
    p0 = pulses;
    pulse_refresh();
    wait_done(2000);
    chk("restart_pulses", 32'(pulses - p0), 32'd34);
    chk("restart_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
